// File: rtl/instruction_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instruction_prefetch_buffer
//
// Fetch stage front end. Keeps the fetch PC, issues one request at a time to
// instruction memory and queues returned words (with their PC) in a small
// FIFO. The decode side sees the head entry through a valid/ready handshake.
// A redirect flushes the queue and any in-flight fetch and restarts fetching
// at the (word-aligned) target.
//
// Optional build macro: PREFETCH_STATS_EN adds FetchCount / FlushCount.
//
// Ports:
//   Clk, Reset            rising-edge clock, asynchronous active-high reset
//   IMemReq, IMemAddr     registered one-cycle request pulse and its address
//   IMemValid, IMemData   memory response strobe and instruction word
//   Redirect,
//   RedirectTarget        flush-and-restart request and new fetch PC
//   Instruction, InstrPC,
//   InstrValid            registered head-of-queue entry (zero when empty)
//   InstrReady            consumer accepts the head entry this cycle
//   FetchCount,
//   FlushCount            (PREFETCH_STATS_EN only) saturating event counters
// -----------------------------------------------------------------------------

// Checker: the issue rule must keep the queue from being written while full.
module instruction_prefetch_buffer_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          Clk,
  input logic          Reset,
  input logic          push,
  input logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  a_no_overflow: assert property (@(posedge Clk) disable iff (Reset) !(push && (count == FULL)));
endmodule

module instruction_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemData,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0] FetchCount,
  output logic [15:0] FlushCount
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic           req_q, req_d;
  logic [31:0]    req_addr_q, req_addr_d;
  logic [63:0]    mem_q [DEPTH];
  logic [63:0]    mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d, count_after_pop_s;
  logic [31:0]    instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic           valid_q, valid_d;
  logic           push_s, pop_s;
  logic [31:0]    target_s;

  // Fetch FSM: decides when to issue, where fetch PC goes, and whether a response is queued.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = 1'b0;
    req_addr_d = 32'h0;
    push_s     = 1'b0;
    pop_s      = valid_q & InstrReady;
    target_s   = RedirectTarget & 32'hFFFF_FFFC;
    // A slot freed by this cycle's pop may be refilled immediately.
    count_after_pop_s = count_q - CW'(pop_s);
    case (state_q)
      S_IDLE: begin
        if (Redirect) begin
          fetch_pc_d = target_s;
          state_d    = S_IDLE;
        end else if (count_after_pop_s < DEPTH_C) begin
          req_d      = 1'b1;
          req_addr_d = fetch_pc_q;
          state_d    = S_WAIT;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (Redirect) begin
          // A response arriving with the redirect is dropped; otherwise it is still owed.
          fetch_pc_d = target_s;
          state_d    = IMemValid ? S_IDLE : S_DROP;
        end else if (IMemValid) begin
          push_s     = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_IDLE;
        end else begin
          state_d    = S_WAIT;
        end
      end
      S_DROP: begin
        if (Redirect) begin
          // If the stale response lands in the same cycle it is consumed here,
          // so nothing is left outstanding and waiting on would never end.
          fetch_pc_d = target_s;
          state_d    = IMemValid ? S_IDLE : S_DROP;
        end else if (IMemValid) begin
          state_d    = S_IDLE;
        end else begin
          state_d    = S_DROP;
        end
      end
      default: begin
        state_d    = S_IDLE;
      end
    endcase
  end

  // Queue update and next head entry; redirect overrides any push or pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (Redirect) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = {fetch_pc_q, IMemData};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d        = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
    // Head outputs are registered from the post-update queue, so empty shows zeros.
    if (count_d != {CW{1'b0}}) begin
      {instr_pc_d, instr_d} = mem_d[rd_ptr_d];
      valid_d               = 1'b1;
    end else begin
      instr_pc_d = 32'h0;
      instr_d    = 32'h0;
      valid_d    = 1'b0;
    end
  end

  // State, queue and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      req_addr_q <= 32'h0;
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      valid_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'h0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      mem_q      <= mem_d;
    end
  end

  assign IMemReq     = req_q;
  assign IMemAddr    = req_addr_q;
  assign Instruction = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = valid_q;

`ifdef PREFETCH_STATS_EN
  logic [15:0] fetch_count_q, fetch_count_d, flush_count_q, flush_count_d;

  // Saturating counters: queued responses and redirect cycles.
  always_comb begin
    if (push_s && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (Redirect && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // Counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_count_q <= 16'h0;
      flush_count_q <= 16'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
  assign FlushCount = flush_count_q;
`endif

  instruction_prefetch_buffer_chk #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_chk (
    .Clk  (Clk),
    .Reset(Reset),
    .push (push_s),
    .count(count_q)
  );

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Bench for instruction_prefetch_buffer: a cycle table for steady fetch after
// reset, plus short sequences for back-pressure, redirects and the stats build.
module tb_instruction_prefetch_buffer;

  logic        Clk;
  logic        Reset;
  logic        IMemReq, u2_req;
  logic [31:0] IMemAddr, u2_addr;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] Instruction, InstrPC, u2_instr, u2_pc;
  logic        InstrValid, u2_valid;
  logic        InstrReady;
`ifdef PREFETCH_STATS_EN
  logic [15:0] FetchCount, FlushCount, u2_fetch_cnt, u2_flush_cnt;
`endif

  int          total;
  int          bad;
  int          mem_lat;
  int          rem;
  logic [31:0] pend_addr;

  typedef struct {
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_addr2;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [9];

  instruction_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Reset(Reset),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemValid(IMemValid), .IMemData(IMemData),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .Instruction(Instruction), .InstrPC(InstrPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady)
`ifdef PREFETCH_STATS_EN
    , .FetchCount(FetchCount), .FlushCount(FlushCount)
`endif
  );

  // Second instance only to observe PC wrap from a high reset PC.
  instruction_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u2 (
    .Clk(Clk), .Reset(Reset),
    .IMemReq(u2_req), .IMemAddr(u2_addr),
    .IMemValid(IMemValid), .IMemData(IMemData),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .Instruction(u2_instr), .InstrPC(u2_pc),
    .InstrValid(u2_valid), .InstrReady(InstrReady)
`ifdef PREFETCH_STATS_EN
    , .FetchCount(u2_fetch_cnt), .FlushCount(u2_flush_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: answers the request seen in cycle c during cycle c+mem_lat, data = ~addr.
  always @(negedge Clk) begin
    if (Reset) begin
      rem       = 0;
      IMemValid = 1'b0;
      IMemData  = 32'h0;
    end else begin
      IMemValid = 1'b0;
      IMemData  = 32'hDEAD_BEEF;
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) begin
          IMemValid = 1'b1;
          IMemData  = ~pend_addr;
        end
      end
      if (IMemReq === 1'b1) begin
        rem       = mem_lat;
        pend_addr = IMemAddr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Asserts reset between edges, checks outputs clear immediately, then releases on a negedge.
  task automatic do_reset(input string name);
    @(posedge Clk);
    #2;
    Reset    = 1'b1;
    Redirect = 1'b0;
    #1;
    chk({name, "_rst_req"},   {31'h0, IMemReq},    32'h0);
    chk({name, "_rst_addr"},  IMemAddr,            32'h0);
    chk({name, "_rst_valid"}, {31'h0, InstrValid}, 32'h0);
    chk({name, "_rst_instr"}, Instruction,         32'h0);
    chk({name, "_rst_pc"},    InstrPC,             32'h0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_req(input string name, input int budget);
    int n;
    n = 0;
    @(negedge Clk);
    while (IMemReq !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    total++;
    if (IMemReq !== 1'b1) begin
      bad++;
      $display("FAIL %s: got req=%b after %0d cycles want req=1", name, IMemReq, budget);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    @(negedge Clk);
    while (InstrValid !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    total++;
    if (InstrValid !== 1'b1) begin
      bad++;
      $display("FAIL %s: got valid=%b after %0d cycles want valid=1", name, InstrValid, budget);
    end
  endtask

  initial begin
    int n;
    total          = 0;
    bad            = 0;
    Reset          = 1'b1;
    Redirect       = 1'b0;
    RedirectTarget = 32'h0;
    InstrReady     = 1'b1;
    mem_lat        = 1;

    // Steady fetch, latency 1, always ready: req every 3 cycles, head 2 cycles after req.
    vecs[0] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF8, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFB, 32'h0000_0004};
    vecs[6] = '{1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFF7, 32'h0000_0008};

    do_reset("s1");
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      chk($sformatf("s1_req[%0d]", i),    {31'h0, IMemReq},    {31'h0, vecs[i].exp_req});
      chk($sformatf("s1_u2req[%0d]", i),  {31'h0, u2_req},     {31'h0, vecs[i].exp_req});
      if (vecs[i].exp_req) begin
        chk($sformatf("s1_addr[%0d]", i),   IMemAddr, vecs[i].exp_addr);
        chk($sformatf("s1_u2addr[%0d]", i), u2_addr,  vecs[i].exp_addr2);
      end
      chk($sformatf("s1_valid[%0d]", i),  {31'h0, InstrValid}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("s1_instr[%0d]", i),  Instruction,         vecs[i].exp_instr);
      chk($sformatf("s1_pc[%0d]", i),     InstrPC,             vecs[i].exp_pc);
    end

    // Back-pressure: queue fills with exactly 4 requests, one pop frees exactly one more.
    InstrReady = 1'b0;
    do_reset("s2");
    n = 0;
    repeat (40) begin
      @(negedge Clk);
      if (IMemReq === 1'b1) n++;
    end
    chk("s2_req_count_full", n, 32'd4);
    chk("s2_head_valid", {31'h0, InstrValid}, 32'h1);
    chk("s2_head_pc",    InstrPC,             32'h0);
    InstrReady = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      InstrReady = 1'b0;
      if (IMemReq === 1'b1) n++;
    end
    chk("s2_req_count_one", n, 32'd1);
    chk("s2_head2_valid", {31'h0, InstrValid}, 32'h1);
    chk("s2_head2_pc",    InstrPC,             32'h4);
    chk("s2_head2_instr", Instruction,         32'hFFFF_FFFB);

    // Redirect while a latency-3 fetch is outstanding: response dropped, restart at 0x100.
    mem_lat    = 3;
    InstrReady = 1'b1;
    do_reset("s3");
    wait_req("s3_first_req", 10);
    chk("s3_first_addr", IMemAddr, 32'h0);
    @(negedge Clk);
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0102;
    @(negedge Clk);
    Redirect = 1'b0;
    chk("s3_empty_after", {31'h0, InstrValid}, 32'h0);
    wait_req("s3_restart_req", 10);
    chk("s3_restart_addr", IMemAddr, 32'h0000_0100);
    wait_valid("s3_head_wait", 20);
    chk("s3_head_pc",    InstrPC,     32'h0000_0100);
    chk("s3_head_instr", Instruction, 32'hFFFF_FEFF);

    // Redirect together with an arriving response and a pop: nothing queued, restart at target.
    mem_lat    = 1;
    InstrReady = 1'b0;
    do_reset("s4");
    wait_req("s4_req0", 10);
    wait_req("s4_req1", 10);
    chk("s4_req1_addr", IMemAddr, 32'h4);
    @(negedge Clk);
    chk("s4_head_before", {31'h0, InstrValid}, 32'h1);
    chk("s4_pc_before",   InstrPC,             32'h0);
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0200;
    InstrReady     = 1'b1;
    @(negedge Clk);
    Redirect = 1'b0;
    chk("s4_empty_valid", {31'h0, InstrValid}, 32'h0);
    chk("s4_empty_instr", Instruction,         32'h0);
    chk("s4_empty_pc",    InstrPC,             32'h0);
    wait_req("s4_restart_req", 10);
    chk("s4_restart_addr", IMemAddr, 32'h0000_0200);
    wait_valid("s4_head_wait", 20);
    chk("s4_head_pc",    InstrPC,     32'h0000_0200);
    chk("s4_head_instr", Instruction, 32'hFFFF_FDFF);

`ifdef PREFETCH_STATS_EN
    // Five queued fetches, then two redirects, the first dropping the sixth fetch.
    mem_lat    = 1;
    InstrReady = 1'b1;
    do_reset("s5");
    chk("s5_rst_fetch", {16'h0, FetchCount}, 32'h0);
    chk("s5_rst_flush", {16'h0, FlushCount}, 32'h0);
    n = 0;
    @(negedge Clk);
    while (!(IMemReq === 1'b1 && IMemAddr == 32'd20) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("s5_sixth_req", {31'h0, IMemReq}, 32'h1);
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0300;
    @(negedge Clk);
    Redirect = 1'b0;
    @(negedge Clk);
    Redirect       = 1'b1;
    RedirectTarget = 32'h0000_0400;
    @(negedge Clk);
    Redirect = 1'b0;
    chk("s5_fetch_count", {16'h0, FetchCount}, 32'd5);
    chk("s5_flush_count", {16'h0, FlushCount}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
